// File: rtl/mem_block_engine.sv
// -----------------------------------------------------------------------------
// mem_block_engine
//
// Purpose:
//   Initiator on the data memory interface. A start pulse makes it walk a
//   block of words. In copy mode (mode=0) each word is read from the source
//   region and written to the destination region. In sum-only mode (mode=1)
//   the words are only read. Every word read is added into a wrapping
//   two's-complement 32-bit checksum.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   start           begin an operation (sampled only when idle)
//   mode            0 = copy, 1 = sum-only
//   src_addr        first source word address
//   dst_addr        first destination word address (unused in sum-only)
//   len             number of words to process (0 is legal)
//   busy            operation in progress, including the done cycle
//   done            one-cycle completion pulse
//   sum             running checksum of words read
//   mem_rd/mem_wrt  memory strobes (registered, never both high)
//   mem_addr        memory word address (registered)
//   mem_datain      write data to memory (registered word buffer)
//   mem_dataout     read data from memory, valid at the posedge after mem_rd
// -----------------------------------------------------------------------------
module mem_block_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              mem_rd,
    output logic              mem_wrt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              rd_q, rd_d;
    logic              wrt_q, wrt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] datain_q, datain_d;

    logic [LEN_W-1:0]  cnt_inc_s;
    logic              last_word_s;

    assign busy       = busy_q;
    assign done       = done_q;
    assign sum        = sum_q;
    assign mem_rd     = rd_q;
    assign mem_wrt    = wrt_q;
    assign mem_addr   = addr_q;
    assign mem_datain = datain_q;

    // Counter increment and last-word detect; compared one bit wider so a
    // length of 65535 needs no special case.
    always_comb begin
        cnt_inc_s   = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
        last_word_s = (({1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});
    end

    // Next-state and registered-output logic. Strobes default low so they are
    // high for exactly one cycle unless a state re-asserts them.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        rd_d     = 1'b0;
        wrt_d    = 1'b0;
        addr_d   = addr_q;
        datain_d = datain_q;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high during the done cycle; starts seen
                // then are treated as arriving while busy.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len;
                    mode_d = mode;
                    cnt_d  = {LEN_W{1'b0}};
                    sum_d  = {DATA_W{1'b0}};
                    busy_d = 1'b1;
                    if (len == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                        addr_d  = src_addr;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_READ: begin
                // Read data for the address presented last cycle is valid now.
                sum_d    = sum_q + mem_dataout;
                datain_d = mem_dataout;
                if (!mode_q) begin
                    state_d = S_WRITE;
                    wrt_d   = 1'b1;
                    addr_d  = dst_q + ADDR_W'(cnt_q);
                end else begin
                    cnt_d = cnt_inc_s;
                    if (last_word_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                        addr_d  = src_q + ADDR_W'(cnt_inc_s);
                    end
                end
            end

            S_WRITE: begin
                cnt_d = cnt_inc_s;
                if (last_word_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                    rd_d    = 1'b1;
                    addr_d  = src_q + ADDR_W'(cnt_inc_s);
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears strobes before the memory's
    // negedge so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_q    <= {ADDR_W{1'b0}};
            dst_q    <= {ADDR_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            mode_q   <= 1'b0;
            cnt_q    <= {LEN_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= {DATA_W{1'b0}};
            rd_q     <= 1'b0;
            wrt_q    <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            datain_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            rd_q     <= rd_d;
            wrt_q    <= wrt_d;
            addr_q   <= addr_d;
            datain_q <= datain_d;
        end
    end

endmodule

// File: tb/tb_mem_block_engine.sv
module tb_mem_block_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        mem_rd;
    logic        mem_wrt;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    mem_block_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .sum(sum),
        .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // Memory model: acts on negedge, decodes the low 16 address bits.
    logic [31:0] mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = 16'd0;
    logic [31:0] tb_wd = 32'd0;

    always @(negedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (mem_wrt === 1'b1) mem[mem_addr[15:0]] <= mem_datain;
        if (mem_rd === 1'b1) mem_dataout <= mem[mem_addr[15:0]];
    end

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int exp_dones = 0;

    typedef struct {
        logic [31:0] sum;
        int          lat;
        int          rd;
        int          wrt;
        logic [31:0] first;
        logic [31:0] last;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
            miscompares++;
        end
    endtask

    // Monitor: tracks each operation from busy rise and checks it on done.
    int          cyc = 0;
    int          t0 = 0;
    int          rd_cnt = 0;
    int          wrt_cnt = 0;
    logic        first_set = 1'b0;
    logic [31:0] first_a = 32'd0;
    logic [31:0] last_a = 32'd0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b1) begin
            busy_prev = 1'b0;
        end else begin
            if (busy === 1'b1 && !busy_prev) begin
                t0 = cyc; rd_cnt = 0; wrt_cnt = 0; first_set = 1'b0;
            end
            if (mem_rd === 1'b1 && mem_wrt === 1'b1) begin
                $display("FAIL rd_wrt_overlap: got both strobes high at addr %0h", mem_addr);
                miscompares++;
            end
            if ((mem_rd === 1'b1 || mem_wrt === 1'b1) && busy !== 1'b1) begin
                $display("FAIL strobe_idle: got strobe with busy=%b required busy=1", busy);
                miscompares++;
            end
            if (mem_rd === 1'b1) begin
                rd_cnt++;
                if (!first_set) first_a = mem_addr;
                first_set = 1'b1;
                last_a = mem_addr;
            end
            if (mem_wrt === 1'b1) wrt_cnt++;
            if (done === 1'b1) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_done: got done with empty scoreboard, required none");
                    miscompares++;
                end else begin
                    e = sb.pop_front();
                    chk("sum", sum, e.sum);
                    chk("latency", cyc - t0, e.lat);
                    chk("rd_count", rd_cnt, e.rd);
                    chk("wrt_count", wrt_cnt, e.wrt);
                    if (e.rd > 0) begin
                        chk("first_rd_addr", first_a, e.first);
                        chk("last_rd_addr", last_a, e.last);
                    end
                end
            end
            busy_prev = (busy === 1'b1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        step();
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic pulse_start(input logic m, input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        step();
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n;
        step();
        start = 1'b0; mode = ~m; src_addr = 32'h5555_0000; dst_addr = 32'h6666_0000; len = 16'd9;
    endtask

    task automatic push(input logic [31:0] s, input int lat, input int r, input int w,
                        input logic [31:0] fa, input logic [31:0] la);
        exp_t e;
        e.sum = s; e.lat = lat; e.rd = r; e.wrt = w; e.first = fa; e.last = la;
        sb.push_back(e);
        exp_dones++;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (busy === 1'b0 && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            $display("FAIL timeout: got busy=%b pending=%0d, required idle with 0 pending", busy, sb.size());
            miscompares++;
            sb.delete();
        end
    endtask

    task automatic load_block();
        poke(16'd2, 32'd3);
        poke(16'd3, 32'hFFFF_FFFC);
        poke(16'd4, 32'd5);
        poke(16'd5, 32'd2);
        poke(16'd6, 32'd20);
    endtask

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = 32'd0; dst_addr = 32'd0; len = 16'd0;
        step(); step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_wrt", mem_wrt, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_sum", sum, 32'd0);
        rst = 1'b0;

        load_block();

        // Sum-only: 3-4+5+2+20 = 26, done at start+6.
        push(32'd26, 6, 5, 0, 32'd2, 32'd6);
        pulse_start(1'b1, 32'd2, 32'd0, 16'd5);
        wait_idle();
        step(); step();
        chk("sum_hold", sum, 32'd26);

        // Copy 2..6 -> 100..104, done at start+11.
        push(32'd26, 11, 5, 5, 32'd2, 32'd6);
        pulse_start(1'b0, 32'd2, 32'd100, 16'd5);
        wait_idle();
        chk("copy_mem100", mem[100], 32'd3);
        chk("copy_mem101", mem[101], 32'hFFFF_FFFC);
        chk("copy_mem102", mem[102], 32'd5);
        chk("copy_mem103", mem[103], 32'd2);
        chk("copy_mem104", mem[104], 32'd20);

        // len=0: done at start+1, no strobes, sum cleared.
        push(32'd0, 1, 0, 0, 32'd0, 32'd0);
        pulse_start(1'b0, 32'd2, 32'd100, 16'd0);
        wait_idle();

        // Overlap dst=src+1: first word replicated.
        push(32'd9, 7, 3, 3, 32'd2, 32'd4);
        pulse_start(1'b0, 32'd2, 32'd3, 16'd3);
        wait_idle();
        chk("overlap_mem3", mem[3], 32'd3);
        chk("overlap_mem4", mem[4], 32'd3);
        chk("overlap_mem5", mem[5], 32'd3);

        // Address wrap: 0xFFFFFFFF then 0.
        poke(16'hFFFF, 32'd7);
        poke(16'h0000, 32'd1);
        push(32'd8, 3, 2, 0, 32'hFFFF_FFFF, 32'd0);
        pulse_start(1'b1, 32'hFFFF_FFFF, 32'd0, 16'd2);
        wait_idle();

        // Reset during the write of word 2 of a copy to 200.
        load_block();
        for (int a = 200; a < 205; a++) poke(16'(a), 32'hDEAD_BEEF);
        pulse_start(1'b0, 32'd2, 32'd200, 16'd5);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_rd === 1'b1 && mem_addr === 32'd4) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("abort_point_found", found, 1'b1);
        rst = 1'b1;
        step();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_wrt", mem_wrt, 1'b0);
        chk("abort_rd", mem_rd, 1'b0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_datain", mem_datain, 32'd0);
        chk("abort_sum", sum, 32'd0);
        rst = 1'b0;
        step(); step();
        chk("abort_mem200", mem[200], 32'd3);
        chk("abort_mem201", mem[201], 32'hFFFF_FFFC);
        chk("abort_mem202", mem[202], 32'hDEAD_BEEF);

        // Fresh start after reset.
        push(32'd26, 6, 5, 0, 32'd2, 32'd6);
        pulse_start(1'b1, 32'd2, 32'd0, 16'd5);
        wait_idle();

        // Start while busy is ignored.
        push(32'd26, 11, 5, 5, 32'd2, 32'd6);
        pulse_start(1'b0, 32'd2, 32'd300, 16'd5);
        step(); step();
        pulse_start(1'b1, 32'd0, 32'd0, 16'd1);
        wait_idle();
        chk("busy_copy_mem304", mem[304], 32'd20);

        // Overflow wrap: 0x7FFFFFFF + 1.
        poke(16'd10, 32'h7FFF_FFFF);
        poke(16'd11, 32'd1);
        push(32'h8000_0000, 3, 2, 0, 32'd10, 32'd11);
        pulse_start(1'b1, 32'd10, 32'd0, 16'd2);
        wait_idle();

        step(); step();
        chk("done_count", done_cnt, exp_dones);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_block_engine.md
Name: mem_block_engine

Overview:
- Initiator side of the data memory interface: drives rd, wrt, addr and datain, and consumes dataout.
- On a start pulse it walks a block of words. It either copies them from a source to a destination region, or only reads and sums them.
- It accumulates a signed 32-bit checksum of every word read.
- Sits between the control unit (start/busy/done handshake) and the data memory, and can stand in for the core during memory init and self-test.

Parameters:
- ADDR_W, 32, width of word addresses driven to memory (memory decodes the low 16 bits).
- DATA_W, 32, memory word width.
- LEN_W, 16, width of the block length input.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  begin operation; sampled only in IDLE
- mode  input  1  0 = copy (read + write), 1 = sum-only (read, no write)
- src_addr  input  ADDR_W  first source word address
- dst_addr  input  ADDR_W  first destination word address (ignored when mode=1)
- len  input  LEN_W  number of words to process
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- sum  output  DATA_W  running two's-complement sum of words read
- mem_rd  output  1  to memory rd
- mem_wrt  output  1  to memory wrt
- mem_addr  output  ADDR_W  to memory addr
- mem_datain  output  DATA_W  to memory datain (write data)
- mem_dataout  input  DATA_W  from memory dataout (read data)

Behaviour:
- **Memory timing.** The memory acts on the negedge of clk. All mem_* outputs are registered on posedge, so they are stable across the following negedge. Read data is valid at the next posedge.
- **Reset.** On rst=1 at posedge:
  - state=IDLE.
  - busy, done, mem_rd and mem_wrt are 0.
  - mem_addr, mem_datain and sum are 0.
  - The word counter is 0.
  - Reset mid-operation aborts immediately. mem_wrt drops before the next negedge, so no write occurs in the reset cycle; writes already completed stay.
- **State IDLE.**
  - start=1: latch src_addr, dst_addr, len and mode; clear sum and the counter; set busy=1.
  - If the latched len=0, go to DONE.
  - Otherwise go to READ with mem_rd=1 and mem_addr=src.
  - start=0: stay in IDLE.
- **State READ** (mem_rd=1 held for exactly one cycle):
  - At the next posedge capture mem_dataout into the word buffer and do sum <= sum + word, wrapping mod 2^32.
  - mode=0: go to WRITE with mem_rd=0, mem_wrt=1, mem_addr=dst+i, mem_datain=word.
  - mode=1: increment i. If i+1==len go to DONE; otherwise stay in READ with mem_addr=src+i+1.
- **State WRITE** (mem_wrt=1 for exactly one cycle): increment i. If i+1==len go to DONE; otherwise go to READ with mem_rd=1, mem_addr=src+i+1.
- **State DONE.**
  - done=1 for one cycle; busy stays 1 in this cycle and mem_rd = mem_wrt = 0.
  - Next cycle: IDLE, busy=0, done=0.
  - sum holds its final value until the next accepted start or rst.
- **Latency.** With start accepted at posedge T, done is high in the cycle after posedge:
  - mode=0: T+2N+1.
  - mode=1: T+N+1.
  - len=0: T+1.
- **Invariants.**
  - mem_rd and mem_wrt are never both 1.
  - Never asserted outside READ/WRITE.
- **Address arithmetic.**
  - src+i and dst+i wrap mod 2^ADDR_W.
  - len is unsigned; the maximum 65535 is valid.
- **Start while busy** is ignored, and the latched operands are unaffected by input changes.
- **Overlapping regions.** Forward copy only, no overlap protection. With dst=src+1 the first word is replicated N times; this is defined behaviour.

Test Plan:
- **Sum-only.** Memory [2..6] = 3, -4, 5, 2, 20. start, mode=1, src=2, len=5.
  - Expect 5 single-cycle reads at addresses 2..6, no mem_wrt.
  - done 6 cycles after start; sum=26.
- **Copy.** Same preload. mode=0, src=2, dst=100, len=5.
  - Expect alternating rd/wrt.
  - Memory [100..104] = 3, -4, 5, 2, 20; done at start+11; sum=26.
- **len=0.** mode=0, len=0.
  - done pulses at start+1, sum=0, no mem_rd/mem_wrt ever asserted.
- **Overlap and wrap.**
  - mode=0, src=2, dst=3, len=3: memory [3..5] all 3.
  - Separately, [0xFFFFFFFF]=7 and [0]=1 (memory decodes the low 16 bits, so address 0xFFFFFFFF is row 0xFFFF), mode=1, src=0xFFFFFFFF, len=2: mem_addr goes 0xFFFFFFFF then 0; sum=8.
- **Reset mid-copy.** Assert rst during the WRITE of word 2 (i=2) of a len=5 copy.
  - Outputs read 0 the next cycle; dst+2 is not written; words 0..1 are written.
  - A fresh start works normally afterwards.
- **Start while busy and sum overflow.**
  - Pulse start during a copy: it is ignored and the done count is unchanged.
  - Words 0x7FFFFFFF and 1, mode=1: sum=0x80000000.
